// File: rtl/aes_pkg.sv
// Shared widths and state encoding for the AES host ingress buffer.
package aes_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORDS   = BLOCK_W / WORD_W;
  localparam int unsigned CNT_W   = $clog2(WORDS);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    LOAD = 2'd2
  } in_state_t;

endpackage

// File: rtl/aes_word_assembler.sv
// Packs successive host words into a block, word 0 in the low lane; flags the lane-3 write.
module aes_word_assembler
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [WORD_W-1:0]  data,
  output logic [BLOCK_W-1:0] block,
  output logic               last,
  output logic [CNT_W-1:0]   cnt
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      block <= '0;
      cnt   <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        if (cnt == CNT_W'(i)) block[i*WORD_W +: WORD_W] <= data;
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = we && (cnt == CNT_W'(WORDS - 1));

endmodule

// File: rtl/aes_input_buffer.sv
// Deserialises 32-bit host words into 128-bit key/text blocks and strobes the AES core load.
module aes_input_buffer
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_i,
  input  logic               sel_i,
  input  logic [WORD_W-1:0]  data_i,
  input  logic               core_busy_i,
  output logic               ready_o,
  output logic               ld_o,
  output logic [BLOCK_W-1:0] text_o,
  output logic [BLOCK_W-1:0] key_o,
  output logic               key_valid_o,
  output logic               ovf_o
);

  in_state_t        state, state_d;
  logic             ready_d, ld_d;
  logic             key_we, text_we;
  logic             key_last, text_last;
  logic [CNT_W-1:0] kcnt, tcnt;
  logic             unused_tcnt;

  // ready_o is only high in FILL, so it gates both word types
  assign key_we      = wr_i && ready_o && sel_i;
  assign text_we     = wr_i && ready_o && !sel_i;
  assign unused_tcnt = ^tcnt;

  aes_word_assembler u_key (
    .clk   (clk),
    .rst   (rst),
    .we    (key_we),
    .data  (data_i),
    .block (key_o),
    .last  (key_last),
    .cnt   (kcnt)
  );

  aes_word_assembler u_text (
    .clk   (clk),
    .rst   (rst),
    .we    (text_we),
    .data  (data_i),
    .block (text_o),
    .last  (text_last),
    .cnt   (tcnt)
  );

  // Next state; ready/ld are decoded from the next state so they register alongside it
  always_comb begin
    state_d = state;
    ready_d = 1'b0;
    ld_d    = 1'b0;
    case (state)
      FILL:    if (text_last) state_d = FULL;
      FULL:    if (key_valid_o && !core_busy_i) state_d = LOAD;
      LOAD:    state_d = FILL;
      default: state_d = FILL;
    endcase
    ready_d = (state_d == FILL);
    ld_d    = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FILL;
      ready_o     <= 1'b1;
      ld_o        <= 1'b0;
      ovf_o       <= 1'b0;
      key_valid_o <= 1'b0;
    end else begin
      state   <= state_d;
      ready_o <= ready_d;
      ld_o    <= ld_d;
      if (wr_i && !ready_o) ovf_o <= 1'b1;
      if (key_last) begin
        key_valid_o <= 1'b1;
      end else if (key_we && (kcnt == '0)) begin
        key_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_input_buffer.sv
// Directed bench for aes_input_buffer with a load scoreboard of expected {text, key} pairs.
module tb_aes_input_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_i;
  logic         sel_i;
  logic [31:0]  data_i;
  logic         core_busy_i;
  logic         ready_o;
  logic         ld_o;
  logic [127:0] text_o;
  logic [127:0] key_o;
  logic         key_valid_o;
  logic         ovf_o;

  int           checks = 0;
  int           errors = 0;
  int           ld_count = 0;
  logic [255:0] sb_q[$];

  localparam logic [127:0] KEY_A  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] TEXT_A = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [127:0] KEY_B  = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [127:0] TEXT_B = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  aes_input_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .wr_i        (wr_i),
    .sel_i       (sel_i),
    .data_i      (data_i),
    .core_busy_i (core_busy_i),
    .ready_o     (ready_o),
    .ld_o        (ld_o),
    .text_o      (text_o),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every load pulse must match the oldest expected {text, key} pair
  always @(negedge clk) begin
    if (rst === 1'b1 && ld_o === 1'b1) begin
      ld_count++;
      if (sb_q.size() == 0) begin
        chk("unexpected_ld", 128'd1, 128'd0);
      end else begin
        logic [255:0] e;
        e = sb_q.pop_front();
        chk("ld_text", text_o, e[255:128]);
        chk("ld_key", key_o, e[127:0]);
      end
    end
  end

  task automatic do_reset();
    rst  = 1'b0;
    wr_i = 1'b1;            // a word presented during reset must be discarded
    sel_i = 1'b0;
    data_i = 32'hA5A5A5A5;
    tick();
    wr_i = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic wr_word(input logic sel, input logic [31:0] d);
    wr_i   = 1'b1;
    sel_i  = sel;
    data_i = d;
    tick();
    wr_i   = 1'b0;
  endtask

  task automatic wr_block(input logic sel, input logic [127:0] b);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = b[i*32 +: 32];
      wr_word(sel, w);
    end
  endtask

  task automatic wait_ld(input string tag, input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      if (ld_o === 1'b1) seen = 1'b1;
      else tick();
    end
    chk(tag, 128'(seen), 128'd1);
    tick();
    chk({tag, "_one_cycle"}, 128'(ld_o), 128'd0);
  endtask

  initial begin
    int n0;
    rst = 1'b0; wr_i = 1'b0; sel_i = 1'b0; data_i = '0; core_busy_i = 1'b0;

    // Reset state
    do_reset();
    chk("rst_ready", 128'(ready_o), 128'd1);
    chk("rst_ld", 128'(ld_o), 128'd0);
    chk("rst_text", text_o, 128'd0);
    chk("rst_key", key_o, 128'd0);
    chk("rst_kv", 128'(key_valid_o), 128'd0);
    chk("rst_ovf", 128'(ovf_o), 128'd0);

    // Test 1: key then text, exact load latency
    wr_block(1'b1, KEY_A);
    chk("t1_kv", 128'(key_valid_o), 128'd1);
    chk("t1_key", key_o, KEY_A);
    sb_q.push_back({TEXT_A, KEY_A});
    wr_block(1'b0, TEXT_A);
    chk("t1_full_ready", 128'(ready_o), 128'd0);
    chk("t1_full_ld", 128'(ld_o), 128'd0);
    chk("t1_text", text_o, TEXT_A);
    tick();
    chk("t1_ld_n2", 128'(ld_o), 128'd1);
    chk("t1_ready_n2", 128'(ready_o), 128'd0);
    tick();
    chk("t1_ld_n3", 128'(ld_o), 128'd0);
    chk("t1_ready_n3", 128'(ready_o), 128'd1);
    chk("t1_ldcnt", 128'(ld_count), 128'd1);

    // Test 2: text before key stalls in FULL; key words rejected
    do_reset();
    n0 = ld_count;
    wr_block(1'b0, TEXT_A);
    chk("t2_ready", 128'(ready_o), 128'd0);
    wr_block(1'b1, KEY_A);
    chk("t2_ovf", 128'(ovf_o), 128'd1);
    chk("t2_kv", 128'(key_valid_o), 128'd0);
    chk("t2_key", key_o, 128'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("t2_no_ld", 128'(ld_count - n0), 128'd0);
    do_reset();
    chk("t2_ovf_cleared", 128'(ovf_o), 128'd0);
    wr_block(1'b1, KEY_A);
    sb_q.push_back({TEXT_A, KEY_A});
    wr_block(1'b0, TEXT_A);
    tick();
    chk("t2_reload_ld", 128'(ld_o), 128'd1);
    tick();

    // Test 3: core busy holds off the load; writes meanwhile dropped
    do_reset();
    wr_block(1'b1, KEY_B);
    core_busy_i = 1'b1;
    n0 = ld_count;
    sb_q.push_back({TEXT_B, KEY_B});
    wr_block(1'b0, TEXT_B);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) wr_word(1'b0, 32'h12345678);
      else tick();
      chk("t3_busy_no_ld", 128'(ld_o), 128'd0);
    end
    chk("t3_ovf", 128'(ovf_o), 128'd1);
    chk("t3_text_stable", text_o, TEXT_B);
    core_busy_i = 1'b0;
    wait_ld("t3_ld_after_busy", 3);
    chk("t3_ldcnt", 128'(ld_count - n0), 128'd1);

    // Test 4: reset mid-fill discards partial block
    do_reset();
    wr_block(1'b1, KEY_A);
    wr_word(1'b0, 32'hAAAA0000);
    wr_word(1'b0, 32'hAAAA1111);
    n0 = ld_count;
    do_reset();
    chk("t4_text", text_o, 128'd0);
    chk("t4_ready", 128'(ready_o), 128'd1);
    chk("t4_kv", 128'(key_valid_o), 128'd0);
    wr_block(1'b1, KEY_A);
    sb_q.push_back({TEXT_B, KEY_A});
    wr_block(1'b0, TEXT_B);
    chk("t4_lane0", 128'(text_o[31:0]), 128'h89ABCDEF);
    wait_ld("t4_ld", 3);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_one_ld", 128'(ld_count - n0), 128'd1);

    // Test 5: back-to-back blocks with a key change between them
    do_reset();
    n0 = ld_count;
    wr_block(1'b1, KEY_A);
    sb_q.push_back({TEXT_A, KEY_A});
    wr_block(1'b0, TEXT_A);
    wait_ld("t5_ld1", 3);
    wr_word(1'b1, KEY_B[31:0]);
    chk("t5_kv_w0", 128'(key_valid_o), 128'd0);
    wr_word(1'b1, KEY_B[63:32]);
    chk("t5_kv_w1", 128'(key_valid_o), 128'd0);
    wr_word(1'b1, KEY_B[95:64]);
    chk("t5_kv_w2", 128'(key_valid_o), 128'd0);
    wr_word(1'b1, KEY_B[127:96]);
    chk("t5_kv_w3", 128'(key_valid_o), 128'd1);
    chk("t5_key", key_o, KEY_B);
    sb_q.push_back({TEXT_B, KEY_B});
    wr_block(1'b0, TEXT_B);
    wait_ld("t5_ld2", 3);
    chk("t5_ldcnt", 128'(ld_count - n0), 128'd2);
    chk("t5_ovf", 128'(ovf_o), 128'd0);

    tick();
    chk("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
